cpu_sram_arbiter: RTL

//  Shares one single-port synchronous SRAM (1-cycle read latency) between the

---
 rtl/cpu_sram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_sram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the CPU instruction-fetch (I) and load/store (D) ports.
// Default build: D-priority with an I starvation guard; define ARB_ROUND_ROBIN_EN for alternating arbitration.
module cpu_sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              i_req,
  input  logic              i_wr,
  input  logic [3:0]        i_wstrb,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [31:0]       i_rdata,

  input  logic              d_req,
  input  logic              d_wr,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [31:0]       d_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  logic   gnt_i;
  logic   gnt_d;
  logic   owner_vld;
  owner_e owner;

  // Stage 0: grant decision, combinational in the request cycle
`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;  // 1: D won the most recent access, 0: I did

  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (resetn) begin
      if (i_req && d_req) begin
        gnt_d = ~rr_last;
        gnt_i = rr_last;
      end else begin
        gnt_d = d_req;
        gnt_i = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= 1'b0;
    end else if (gnt_i || gnt_d) begin
      rr_last <= gnt_d;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_i;

  always_comb begin
    force_i = i_req && (starve_cnt == CNT_W'(STARVE_MAX));
    gnt_d   = resetn && d_req && !force_i;
    gnt_i   = resetn && i_req && !gnt_d;
  end

  // Counts consecutive refused I cycles; saturates so force_i holds until I wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (i_req && !gnt_i) begin
      if (starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  assign i_addr_ok = gnt_i;
  assign d_addr_ok = gnt_d;

  always_comb begin
    ram_en    = gnt_i || gnt_d;
    ram_wen   = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_d) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
      ram_wen   = d_wr ? d_wstrb : 4'h0;
    end else if (gnt_i) begin
      ram_addr  = i_addr;
      ram_wdata = i_wdata;
      ram_wen   = i_wr ? i_wstrb : 4'h0;
    end
  end

  // Stage 1: response owner, aligned with the SRAM read latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_vld <= 1'b0;
      owner     <= OWN_I;
    end else begin
      owner_vld <= gnt_i || gnt_d;
      if (gnt_d) begin
        owner <= OWN_D;
      end else if (gnt_i) begin
        owner <= OWN_I;
      end
    end
  end

  assign i_data_ok = owner_vld && (owner == OWN_I);
  assign d_data_ok = owner_vld && (owner == OWN_D);
  assign i_rdata   = resetn ? ram_rdata : 32'h0;
  assign d_rdata   = resetn ? ram_rdata : 32'h0;

endmodule
